// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP frame scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lbp_pkg;

  typedef enum logic [2:0] {
    R_IDLE,
    R_WAIT,
    R_RST,
    R_GO,
    R_RUN,
    R_CHK,
    R_DONE,
    R_ERR
  } run_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_WCNT    = 2'b10;

  // Default image geometry and the resulting LBP writes per frame.
  localparam int WIDTH_DEF    = 128;
  localparam int FRAME_PIXELS = WIDTH_DEF * WIDTH_DEF;

  // Write counter width; saturates at all-ones.
  localparam int WCNT_W = 15;

  function automatic int frame_pixels(input int side);
    return side * side;
  endfunction

endpackage

// File: rtl/lbp_frame_sched_if.sv
// Bundle of host-loader, engine and status signals around the frame scheduler.
// Latency: n/a (wiring only).
// Backpressure: loader paced by ld_req/ld_done; engine paced by gray_ready/finish.
interface lbp_frame_sched_if #(parameter int FRM_W = 8);

  logic             start;
  logic [FRM_W-1:0] num_frames;
  logic             ld_req;
  logic             ld_bank;
  logic             ld_done;
  logic             eng_rst;
  logic             eng_gray_ready;
  logic             eng_bank;
  logic             eng_lbp_valid;
  logic             eng_finish;
  logic             busy;
  logic             frame_done;
  logic [FRM_W-1:0] frame_idx;
  logic             done;
  logic             err;
  logic [1:0]       err_code;

  // Host / loader / engine side.
  modport master (
    output start, num_frames, ld_done, eng_lbp_valid, eng_finish,
    input  ld_req, ld_bank, eng_rst, eng_gray_ready, eng_bank,
           busy, frame_done, frame_idx, done, err, err_code
  );

  // Scheduler side.
  modport slave (
    input  start, num_frames, ld_done, eng_lbp_valid, eng_finish,
    output ld_req, ld_bank, eng_rst, eng_gray_ready, eng_bank,
           busy, frame_done, frame_idx, done, err, err_code
  );

endinterface

// File: rtl/lbp_bank_tracker.sv
// Tracks which gray bank holds a loaded frame and requests loads into the free one.
// Latency: ld_done sets full/toggles ld_bank at the next edge; ld_req is combinational.
// Backpressure: ld_req drops while the target bank is still full or all loads are issued.
module lbp_bank_tracker #(
  parameter int FRM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_clr,
  input  logic             active,
  input  logic [FRM_W-1:0] num_frames,
  input  logic             ld_done,
  input  logic             eng_bank,
  input  logic             frm_clr,
  output logic             ld_req,
  output logic             ld_bank,
  output logic [1:0]       full
);

  logic [FRM_W-1:0] loads;
  logic             ld_acc;
  logic [1:0]       set_v;
  logic [1:0]       clr_v;

  // A bank is only requested when it is empty, so a set never lands on a full bank.
  assign ld_req = active && (loads < num_frames) && !full[ld_bank];
  assign ld_acc = ld_done && ld_req;

  // Set (loader) and clear (engine) target different banks and may coincide.
  assign set_v = ld_acc  ? (ld_bank  ? 2'b10 : 2'b01) : 2'b00;
  assign clr_v = frm_clr ? (eng_bank ? 2'b10 : 2'b01) : 2'b00;

  // Full flags, load bank pointer and issued-load count.
  always_ff @(posedge clk) begin
    if (reset || job_clr) begin
      full    <= 2'b00;
      ld_bank <= 1'b0;
      loads   <= '0;
    end else begin
      full <= (full & ~clr_v) | set_v;
      if (ld_acc) begin
        ld_bank <= ~ld_bank;
        loads   <= loads + FRM_W'(1);
      end
    end
  end

endmodule

// File: rtl/lbp_frame_sched.sv
// Frame scheduler: resets and starts the LBP engine per loaded bank, verifies each frame.
// Latency: start->ld_req 1 cycle; ld_done->eng_gray_ready 4 cycles; frame verified 1 cycle after finish.
// Backpressure: engine waits in reset until its bank is full; loader waits on ld_req.
module lbp_frame_sched
  import lbp_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int FRM_W       = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  lbp_frame_sched_if.slave   bus
);

  // Default geometry uses the package constant; other sizes compute it.
  localparam int PIX_INT = (WIDTH == WIDTH_DEF) ? FRAME_PIXELS : frame_pixels(WIDTH);
  localparam logic [WCNT_W-1:0] PIX = WCNT_W'(PIX_INT);
  localparam int WDT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TIMEOUT_CYC - 1);

  run_state_t        state;
  run_state_t        state_nxt;
  logic [1:0]        err_code_nxt;
  logic              rst_cnt;
  logic [WCNT_W-1:0] wcnt;
  logic [WDT_W-1:0]  wdt;
  logic              eng_bank_q;
  logic [FRM_W-1:0]  frame_idx_q;
  logic [FRM_W-1:0]  num_q;
  logic              err_q;
  logic [1:0]        err_code_q;
  logic              eng_rst_q;
  logic [1:0]        full;
  logic              start_acc;
  logic              chk_ok;
  logic              last_frame;
  logic              job_active;

  assign start_acc  = bus.start && ((state == R_IDLE) || (state == R_ERR));
  assign chk_ok     = (state == R_CHK) && (wcnt == PIX);
  assign last_frame = ((frame_idx_q + FRM_W'(1)) == num_q);
  assign job_active = (state inside {R_WAIT, R_RST, R_GO, R_RUN, R_CHK});

  lbp_bank_tracker #(.FRM_W(FRM_W)) u_trk (
    .clk        (clk),
    .reset      (reset),
    .job_clr    (start_acc),
    .active     (job_active),
    .num_frames (num_q),
    .ld_done    (bus.ld_done),
    .eng_bank   (eng_bank_q),
    .frm_clr    (chk_ok),
    .ld_req     (bus.ld_req),
    .ld_bank    (bus.ld_bank),
    .full       (full)
  );

  // Next-state decode for the run FSM, including the error code taken on entry to R_ERR.
  always_comb begin
    state_nxt    = state;
    err_code_nxt = ERR_NONE;
    case (state)
      R_IDLE, R_ERR: begin
        if (start_acc) state_nxt = (bus.num_frames == '0) ? R_DONE : R_WAIT;
      end
      R_WAIT: if (full[eng_bank_q]) state_nxt = R_RST;
      R_RST:  if (rst_cnt) state_nxt = R_GO;
      R_GO:   state_nxt = R_RUN;
      R_RUN: begin
        // Finish on the last watchdog cycle still completes the frame.
        if (bus.eng_finish) begin
          state_nxt = R_CHK;
        end else if (wdt == WDT_LAST) begin
          state_nxt    = R_ERR;
          err_code_nxt = ERR_TIMEOUT;
        end
      end
      R_CHK: begin
        if (wcnt != PIX) begin
          state_nxt    = R_ERR;
          err_code_nxt = ERR_WCNT;
        end else if (last_frame) begin
          state_nxt = R_DONE;
        end else begin
          state_nxt = R_WAIT;
        end
      end
      R_DONE:  state_nxt = R_IDLE;
      default: state_nxt = R_IDLE;
    endcase
  end

  // State register, counters, job bookkeeping and the registered engine reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= R_IDLE;
      rst_cnt     <= 1'b0;
      wcnt        <= '0;
      wdt         <= '0;
      eng_bank_q  <= 1'b0;
      frame_idx_q <= '0;
      num_q       <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      eng_rst_q   <= 1'b1;
    end else begin
      state     <= state_nxt;
      rst_cnt   <= (state == R_RST) ? ~rst_cnt : 1'b0;
      eng_rst_q <= !(state_nxt inside {R_GO, R_RUN, R_CHK});

      if (state == R_GO) begin
        wcnt <= '0;
        wdt  <= '0;
      end else if (state == R_RUN) begin
        wdt <= wdt + WDT_W'(1);
        if (bus.eng_lbp_valid && (wcnt != '1)) wcnt <= wcnt + WCNT_W'(1);
      end

      if (start_acc) begin
        num_q       <= bus.num_frames;
        frame_idx_q <= '0;
        eng_bank_q  <= 1'b0;
        err_q       <= 1'b0;
        err_code_q  <= ERR_NONE;
      end else if (chk_ok) begin
        frame_idx_q <= frame_idx_q + FRM_W'(1);
        eng_bank_q  <= ~eng_bank_q;
      end

      if ((state_nxt == R_ERR) && (state != R_ERR)) begin
        err_q      <= 1'b1;
        err_code_q <= err_code_nxt;
      end
    end
  end

  assign bus.eng_rst        = eng_rst_q;
  assign bus.eng_gray_ready = (state == R_GO);
  assign bus.eng_bank       = eng_bank_q;
  assign bus.busy           = job_active;
  assign bus.frame_done     = chk_ok;
  assign bus.frame_idx      = frame_idx_q;
  assign bus.done           = (state == R_DONE);
  assign bus.err            = err_q;
  assign bus.err_code       = err_code_q;

endmodule

// File: tb/tb_lbp_frame_sched.sv
// Bench for lbp_frame_sched: table of jobs against loader/engine models plus reset corner cases.
// Latency: n/a.
// Backpressure: loader model answers ld_req after a programmable delay.
module tb_lbp_frame_sched;

  localparam int FRM_W  = 8;
  localparam int BUDGET = 5000;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  lbp_frame_sched_if #(.FRM_W(FRM_W)) bus ();

  lbp_frame_sched #(.WIDTH(16), .FRM_W(FRM_W), .TIMEOUT_CYC(1000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int nf; int nval; int fin; int ld_lat; int busy_start;
    int exp_frames; int exp_err; int exp_code; int exp_idx;
  } vec_t;

  vec_t vecs[9];

  // Model configuration
  int ld_en = 0;
  int ld_lat = 0;
  int ld_cnt = 0;
  int first_ld = -1;
  int cfg_nval = 0;
  int cfg_fin = -1;
  int e_act = 0;
  int e_k = 0;

  // Monitor state
  int gr_cyc_q[$];
  int gr_bank_q[$];
  int fd_tot = 0, done_tot = 0, ldreq_tot = 0, overlap_tot = 0, conflict_tot = 0;
  int err_rise_cyc = -1;
  logic err_prev = 1'b0;
  int run_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Loader model: answers ld_req after ld_lat cycles.
  always @(negedge clk) begin
    bus.ld_done = 1'b0;
    if (ld_en == 0 || !bus.ld_req) begin
      ld_cnt = 0;
    end else if (ld_cnt >= ld_lat) begin
      bus.ld_done = 1'b1;
      ld_cnt = 0;
      if (first_ld < 0) first_ld = cyc;
    end else begin
      ld_cnt++;
    end
  end

  // Engine model: cfg_nval valids from the first RUN cycle, finish at RUN cycle cfg_fin.
  always @(negedge clk) begin
    bus.eng_lbp_valid = 1'b0;
    bus.eng_finish    = 1'b0;
    if (bus.eng_rst) begin
      e_act = 0;
    end else if (bus.eng_gray_ready) begin
      e_act = 1;
      e_k   = 0;
    end else if (e_act != 0) begin
      if (e_k < cfg_nval) bus.eng_lbp_valid = 1'b1;
      if (e_k == cfg_fin) begin
        bus.eng_finish = 1'b1;
        e_act = 0;
      end
      e_k++;
    end
  end

  // Monitor: event counts, engine start log, load/run overlap.
  always @(negedge clk) begin
    if (run_seen != 0 && bus.ld_req) begin
      overlap_tot++;
      if (bus.ld_bank == bus.eng_bank) conflict_tot++;
    end
    if (bus.eng_rst) run_seen = 0;
    if (bus.eng_gray_ready) begin
      gr_cyc_q.push_back(cyc);
      gr_bank_q.push_back(int'(bus.eng_bank));
      run_seen = 1;
    end
    if (bus.frame_done) fd_tot++;
    if (bus.done) done_tot++;
    if (bus.ld_req) ldreq_tot++;
    if (bus.err && !err_prev) err_rise_cyc = cyc;
    err_prev = bus.err;
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ld_req"},     int'(bus.ld_req), 0);
    chk({tag, "_ld_bank"},    int'(bus.ld_bank), 0);
    chk({tag, "_eng_rst"},    int'(bus.eng_rst), 1);
    chk({tag, "_gray_ready"}, int'(bus.eng_gray_ready), 0);
    chk({tag, "_eng_bank"},   int'(bus.eng_bank), 0);
    chk({tag, "_busy"},       int'(bus.busy), 0);
    chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
    chk({tag, "_frame_idx"},  int'(bus.frame_idx), 0);
    chk({tag, "_done"},       int'(bus.done), 0);
    chk({tag, "_err"},        int'(bus.err), 0);
    chk({tag, "_err_code"},   int'(bus.err_code), 0);
  endtask

  task automatic run_job(input vec_t v, input int id);
    int g0, fd0, dn0, lq0, ov0, cf0, n, bad, ngr;
    string p;
    p = $sformatf("v%0d", id);
    cfg_nval = v.nval;
    cfg_fin  = v.fin;
    ld_lat   = v.ld_lat;
    ld_en    = 1;
    @(negedge clk);
    first_ld = -1;
    g0 = gr_cyc_q.size(); fd0 = fd_tot; dn0 = done_tot;
    lq0 = ldreq_tot; ov0 = overlap_tot; cf0 = conflict_tot;
    bus.start = 1'b1;
    bus.num_frames = FRM_W'(v.nf);
    @(negedge clk);
    bus.start = 1'b0;
    chk({p, "_err_clr"},   int'(bus.err), 0);
    chk({p, "_busy_on"},   int'(bus.busy), int'(v.nf > 0));
    chk({p, "_done_next"}, int'(bus.done), int'(v.nf == 0));
    if (v.busy_start != 0) begin
      repeat (3) @(negedge clk);
      bus.start = 1'b1;
      bus.num_frames = FRM_W'(5);
      @(negedge clk);
      bus.start = 1'b0;
    end
    n = 0;
    while (!bus.done && !bus.err && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk({p, "_terminated"}, int'(n < BUDGET), 1);
    repeat (3) @(negedge clk);
    ngr = gr_cyc_q.size() - g0;
    chk({p, "_frame_done_cnt"}, fd_tot - fd0, v.exp_frames);
    chk({p, "_done_cnt"},       done_tot - dn0, (v.exp_err != 0) ? 0 : 1);
    chk({p, "_gray_ready_cnt"}, ngr, v.exp_frames + v.exp_err);
    chk({p, "_err"},            int'(bus.err), v.exp_err);
    chk({p, "_err_code"},       int'(bus.err_code), v.exp_code);
    chk({p, "_frame_idx"},      int'(bus.frame_idx), v.exp_idx);
    chk({p, "_busy_end"},       int'(bus.busy), 0);
    chk({p, "_eng_rst_end"},    int'(bus.eng_rst), 1);
    chk({p, "_bank_conflict"},  conflict_tot - cf0, 0);
    bad = 0;
    for (int i = 0; i < ngr; i++)
      if (gr_bank_q[g0 + i] != (i % 2)) bad++;
    chk({p, "_eng_bank_seq"}, bad, 0);
    if (v.nf == 0) chk({p, "_no_ld_req"}, ldreq_tot - lq0, 0);
    if (id == 0 && ngr > 0) begin
      chk({p, "_ld_to_gray_ready"}, gr_cyc_q[g0] - first_ld, 4);
      chk({p, "_ld_req_cycles"}, ldreq_tot - lq0, v.ld_lat + 1);
    end
    if (id == 1) chk({p, "_load_during_run"}, int'(overlap_tot - ov0 > 0), 1);
    if (v.fin < 0 && ngr > 0) chk({p, "_timeout_cycles"}, err_rise_cyc - gr_cyc_q[gr_cyc_q.size() - 1], 1001);
  endtask

  initial begin
    int n;
    vecs[0] = '{1, 256, 256,  5, 0, 1, 0, 0, 1};
    vecs[1] = '{3, 256, 256, 20, 0, 3, 0, 0, 3};
    vecs[2] = '{1, 255, 255,  3, 0, 0, 1, 2, 0};
    vecs[3] = '{2, 256, 255,  3, 0, 2, 0, 0, 2};
    vecs[4] = '{1, 256, 999,  3, 0, 1, 0, 0, 1};
    vecs[5] = '{1,  10,  -1,  2, 0, 0, 1, 1, 0};
    vecs[6] = '{2, 257, 257,  0, 0, 0, 1, 2, 0};
    vecs[7] = '{0, 256, 256,  3, 0, 0, 0, 0, 0};
    vecs[8] = '{1, 256, 256,  5, 1, 1, 0, 0, 1};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.num_frames = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_job(vecs[i], i);

    // Start latency to ld_req, then reset in the middle of a run.
    ld_en = 0;
    cfg_nval = 256;
    cfg_fin = 256;
    ld_lat = 2;
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_frames = FRM_W'(1);
    chk("ld_req_before_start", int'(bus.ld_req), 0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("ld_req_after_start", int'(bus.ld_req), 1);
    ld_en = 1;
    n = 0;
    while (!bus.eng_gray_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_gray_ready_seen", int'(n < 200), 1);
    repeat (20) @(negedge clk);
    chk("mid_running", int'(bus.eng_rst), 0);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("mid");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_job(vecs[0], 100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
